// File: rtl/map_scroll_ctrl.sv
// Vertical scroll controller for a 4-layer map held in a ring buffer.
// Requests layers from an external generator and times out if one never arrives.
module map_scroll_ctrl #(
    parameter int LAYER_H     = 48,
    parameter int SCROLL_STEP = 4,
    parameter int TIMEOUT     = 255
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       scroll_req,
    input  logic       frame_tick,
    output logic       gen_req,
    input  logic       load_layer_in,
    input  logic [6:0] layer_map_in,
    input  logic [6:0] block_type_in,
    input  logic [1:0] rd_idx,
    output logic [6:0] rd_layer_map,
    output logic [6:0] rd_block_type,
    output logic [5:0] scroll_offset,
    output logic       map_ready,
    output logic       busy,
    output logic       error
);

    typedef enum logic [2:0] {
        IDLE,
        FILL,
        READY,
        SCROLL,
        FETCH,
        ERR
    } state_t;

    state_t     state, state_n;
    logic [6:0] ring_map  [4];
    logic [6:0] ring_type [4];
    logic [1:0] base, base_n;
    logic [2:0] count, count_n;
    logic [5:0] offset_n;
    logic       gen_req_n;
    logic [7:0] tcnt, tcnt_n;
    logic       error_n;
    logic       wr_en;
    logic [1:0] wr_slot;
    logic [6:0] offset_sum;
    logic [8:0] tcnt_inc;
    logic [1:0] rd_slot;

    assign rd_slot       = base + rd_idx;
    assign rd_layer_map  = ring_map[rd_slot];
    assign rd_block_type = ring_type[rd_slot];

    assign offset_sum = {1'b0, scroll_offset} + 7'(SCROLL_STEP);
    assign tcnt_inc   = {1'b0, tcnt} + 9'd1;

    always_comb begin
        state_n   = state;
        base_n    = base;
        count_n   = count;
        offset_n  = scroll_offset;
        gen_req_n = 1'b0;
        tcnt_n    = tcnt;
        error_n   = error;
        wr_en     = 1'b0;
        wr_slot   = count[1:0];
        map_ready = (state == READY);
        busy      = (state == FILL) || (state == SCROLL) || (state == FETCH);

        case (state)
            IDLE: begin
                if (start) begin
                    state_n   = FILL;
                    count_n   = '0;
                    base_n    = '0;
                    gen_req_n = 1'b1;
                    tcnt_n    = '0;
                end
            end
            FILL: begin
                if (load_layer_in) begin
                    wr_en   = 1'b1;
                    wr_slot = count[1:0];
                    count_n = count + 3'd1;
                    tcnt_n  = '0;
                    if (count == 3'd3) begin
                        state_n = READY;
                    end else begin
                        gen_req_n = 1'b1;
                    end
                end else if (tcnt_inc >= 9'(TIMEOUT)) begin
                    state_n = ERR;
                    error_n = 1'b1;
                end else begin
                    tcnt_n = tcnt_inc[7:0];
                end
            end
            READY: begin
                if (scroll_req) begin
                    state_n = SCROLL;
                end
            end
            SCROLL: begin
                if (frame_tick) begin
                    if (offset_sum >= 7'(LAYER_H)) begin
                        offset_n  = '0;
                        base_n    = base + 2'd1;
                        state_n   = FETCH;
                        gen_req_n = 1'b1;
                        tcnt_n    = '0;
                    end else begin
                        offset_n = offset_sum[5:0];
                    end
                end
            end
            FETCH: begin
                // base already advanced, so base+3 is the slot the old bottom layer occupied
                if (load_layer_in) begin
                    wr_en   = 1'b1;
                    wr_slot = base + 2'd3;
                    tcnt_n  = '0;
                    state_n = READY;
                end else if (tcnt_inc >= 9'(TIMEOUT)) begin
                    state_n = ERR;
                    error_n = 1'b1;
                end else begin
                    tcnt_n = tcnt_inc[7:0];
                end
            end
            ERR: begin
                state_n = ERR;
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            base          <= '0;
            count         <= '0;
            scroll_offset <= '0;
            gen_req       <= 1'b0;
            tcnt          <= '0;
            error         <= 1'b0;
        end else begin
            state         <= state_n;
            base          <= base_n;
            count         <= count_n;
            scroll_offset <= offset_n;
            gen_req       <= gen_req_n;
            tcnt          <= tcnt_n;
            error         <= error_n;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned i = 0; i < 4; i++) begin
                ring_map[i]  <= '0;
                ring_type[i] <= '0;
            end
        end else if (wr_en) begin
            ring_map[wr_slot]  <= layer_map_in;
            ring_type[wr_slot] <= block_type_in;
        end
    end

endmodule

// File: tb/tb_map_scroll_ctrl.sv
// Scoreboard bench for map_scroll_ctrl: a generator model answers gen_req after
// two cycles and a queue tracks which layers should be visible, bottom first.
module tb_map_scroll_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       start, scroll_req, frame_tick, gen_req, load_layer_in;
    logic [6:0] layer_map_in, block_type_in, rd_layer_map, rd_block_type;
    logic [1:0] rd_idx;
    logic [5:0] scroll_offset;
    logic       map_ready, busy, error;

    int checks = 0;
    int errors = 0;
    int gen_cnt = 0;
    int resp_delay = 0;
    int next_layer = 0;
    bit gen_auto = 1'b0;
    logic [13:0] vis_q[$];

    map_scroll_ctrl #(.LAYER_H(48), .SCROLL_STEP(4), .TIMEOUT(10)) dut (
        .clk(clk), .rst(rst), .start(start), .scroll_req(scroll_req),
        .frame_tick(frame_tick), .gen_req(gen_req), .load_layer_in(load_layer_in),
        .layer_map_in(layer_map_in), .block_type_in(block_type_in), .rd_idx(rd_idx),
        .rd_layer_map(rd_layer_map), .rd_block_type(rd_block_type),
        .scroll_offset(scroll_offset), .map_ready(map_ready), .busy(busy), .error(error)
    );

    always #5 clk = ~clk;

    // One clock: clear pulses, run the generator model, count gen_req cycles.
    task automatic step;
        @(posedge clk);
        #1;
        start = 1'b0; scroll_req = 1'b0; frame_tick = 1'b0; load_layer_in = 1'b0;
        if (resp_delay > 0) begin
            resp_delay--;
            if (resp_delay == 0) begin
                load_layer_in = 1'b1;
                layer_map_in  = 7'(17 * next_layer + 9);
                block_type_in = 7'(37 * next_layer + 5);
                vis_q.push_back({layer_map_in, block_type_in});
                next_layer++;
            end
        end
        if (gen_req === 1'b1) begin
            gen_cnt++;
            if (gen_auto) resp_delay = 2;
        end
    endtask

    task automatic wait_ready(input string name);
        int n = 0;
        while (map_ready !== 1'b1 && n < 50) begin
            step();
            n++;
        end
        checks++;
        if (map_ready !== 1'b1) begin
            errors++;
            $display("FAIL %s: map_ready=%b after %0d cycles, required 1", name, map_ready, n);
        end
    endtask

    task automatic test_reset;
        rst = 1'b1; start = 0; scroll_req = 0; frame_tick = 0; load_layer_in = 0;
        layer_map_in = '0; block_type_in = '0; rd_idx = '0;
        step(); step();
        rst = 1'b0;
        checks++;
        if ({gen_req, map_ready, busy, error} !== 4'b0000 || scroll_offset !== 6'd0) begin
            errors++;
            $display("FAIL reset_outputs: gen_req=%b map_ready=%b busy=%b error=%b offset=%0d, required all 0",
                     gen_req, map_ready, busy, error, scroll_offset);
        end
        for (int i = 0; i < 4; i++) begin
            rd_idx = 2'(i); #1;
            checks++;
            if (rd_layer_map !== 7'd0 || rd_block_type !== 7'd0) begin
                errors++;
                $display("FAIL reset_ring[%0d]: got %h/%h, required 00/00", i, rd_layer_map, rd_block_type);
            end
        end
    endtask

    task automatic test_fill;
        int g0 = gen_cnt;
        gen_auto = 1'b1;
        start = 1'b1;
        step();
        checks++;
        if (gen_req !== 1'b1 || busy !== 1'b1) begin
            errors++;
            $display("FAIL fill_first_req: gen_req=%b busy=%b, required 1 1", gen_req, busy);
        end
        wait_ready("fill_ready");
        repeat (4) step();
        checks++;
        if (gen_cnt - g0 != 4 || map_ready !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL fill_gen_count: pulses=%0d map_ready=%b busy=%b, required 4 1 0",
                     gen_cnt - g0, map_ready, busy);
        end
        for (int i = 0; i < 4; i++) begin
            rd_idx = 2'(i); #1;
            checks++;
            if ({rd_layer_map, rd_block_type} !== vis_q[i]) begin
                errors++;
                $display("FAIL fill_rd[%0d]: got %h, required %h", i, {rd_layer_map, rd_block_type}, vis_q[i]);
            end
        end
    endtask

    task automatic test_scroll;
        int g0 = gen_cnt;
        logic [5:0] exp_off;
        scroll_req = 1'b1;
        step();
        checks++;
        if (busy !== 1'b1 || map_ready !== 1'b0) begin
            errors++;
            $display("FAIL scroll_enter: busy=%b map_ready=%b, required 1 0", busy, map_ready);
        end
        for (int t = 1; t <= 12; t++) begin
            frame_tick = 1'b1;
            step();
            exp_off = (t == 12) ? 6'd0 : 6'(4 * t);
            checks++;
            if (scroll_offset !== exp_off) begin
                errors++;
                $display("FAIL scroll_offset_tick%0d: got %0d, required %0d", t, scroll_offset, exp_off);
            end
        end
        checks++;
        if (gen_req !== 1'b1) begin
            errors++;
            $display("FAIL scroll_fetch_req: gen_req=%b, required 1", gen_req);
        end
        void'(vis_q.pop_front());
        wait_ready("scroll_ready");
        checks++;
        if (gen_cnt - g0 != 1) begin
            errors++;
            $display("FAIL scroll_gen_count: pulses=%0d, required 1", gen_cnt - g0);
        end
        for (int i = 0; i < 4; i++) begin
            rd_idx = 2'(i); #1;
            checks++;
            if ({rd_layer_map, rd_block_type} !== vis_q[i]) begin
                errors++;
                $display("FAIL scroll_rd[%0d]: got %h, required %h", i, {rd_layer_map, rd_block_type}, vis_q[i]);
            end
        end
    endtask

    task automatic test_wrap;
        for (int s = 0; s < 5; s++) begin
            scroll_req = 1'b1;
            step();
            for (int t = 0; t < 12; t++) begin
                frame_tick = 1'b1;
                step();
            end
            void'(vis_q.pop_front());
            wait_ready("wrap_ready");
            for (int i = 0; i < 4; i++) begin
                rd_idx = 2'(i); #1;
                checks++;
                if ({rd_layer_map, rd_block_type} !== vis_q[i]) begin
                    errors++;
                    $display("FAIL wrap%0d_rd[%0d]: got %h, required %h",
                             s, i, {rd_layer_map, rd_block_type}, vis_q[i]);
                end
            end
        end
    endtask

    task automatic test_drops;
        int g0 = gen_cnt;
        load_layer_in = 1'b1; layer_map_in = 7'h7F; block_type_in = 7'h55;
        step();
        frame_tick = 1'b1;
        step();
        checks++;
        if (map_ready !== 1'b1 || scroll_offset !== 6'd0) begin
            errors++;
            $display("FAIL drop_ready: map_ready=%b offset=%0d, required 1 0", map_ready, scroll_offset);
        end
        scroll_req = 1'b1;
        step();
        frame_tick = 1'b1;
        step();
        scroll_req = 1'b1; start = 1'b1; load_layer_in = 1'b1;
        layer_map_in = 7'h2A; block_type_in = 7'h15;
        step();
        checks++;
        if (scroll_offset !== 6'd4 || busy !== 1'b1 || map_ready !== 1'b0 || gen_cnt != g0) begin
            errors++;
            $display("FAIL drop_scroll: offset=%0d busy=%b map_ready=%b pulses=%0d, required 4 1 0 0",
                     scroll_offset, busy, map_ready, gen_cnt - g0);
        end
        for (int i = 0; i < 4; i++) begin
            rd_idx = 2'(i); #1;
            checks++;
            if ({rd_layer_map, rd_block_type} !== vis_q[i]) begin
                errors++;
                $display("FAIL drop_ring[%0d]: got %h, required %h", i, {rd_layer_map, rd_block_type}, vis_q[i]);
            end
        end
        for (int t = 0; t < 11; t++) begin
            frame_tick = 1'b1;
            step();
        end
        void'(vis_q.pop_front());
        wait_ready("drop_ready2");
        checks++;
        if (gen_cnt - g0 != 1) begin
            errors++;
            $display("FAIL drop_gen_count: pulses=%0d, required 1", gen_cnt - g0);
        end
        for (int i = 0; i < 4; i++) begin
            rd_idx = 2'(i); #1;
            checks++;
            if ({rd_layer_map, rd_block_type} !== vis_q[i]) begin
                errors++;
                $display("FAIL drop_rd[%0d]: got %h, required %h", i, {rd_layer_map, rd_block_type}, vis_q[i]);
            end
        end
    endtask

    task automatic test_reset_mid;
        scroll_req = 1'b1;
        step();
        gen_auto = 1'b0;
        for (int t = 0; t < 12; t++) begin
            frame_tick = 1'b1;
            step();
        end
        step();
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("FAIL rstmid_fetch: busy=%b, required 1", busy);
        end
        rst = 1'b1; load_layer_in = 1'b1; layer_map_in = 7'h33; block_type_in = 7'h4C;
        step();
        rst = 1'b0;
        vis_q.delete();
        checks++;
        if ({gen_req, map_ready, busy, error} !== 4'b0000 || scroll_offset !== 6'd0) begin
            errors++;
            $display("FAIL rstmid_outputs: gen_req=%b map_ready=%b busy=%b error=%b offset=%0d, required all 0",
                     gen_req, map_ready, busy, error, scroll_offset);
        end
        for (int i = 0; i < 4; i++) begin
            rd_idx = 2'(i); #1;
            checks++;
            if (rd_layer_map !== 7'd0 || rd_block_type !== 7'd0) begin
                errors++;
                $display("FAIL rstmid_ring[%0d]: got %h/%h, required 00/00", i, rd_layer_map, rd_block_type);
            end
        end
    endtask

    task automatic test_timeout;
        start = 1'b1;
        step();
        checks++;
        if (gen_req !== 1'b1 || busy !== 1'b1) begin
            errors++;
            $display("FAIL timeout_req: gen_req=%b busy=%b, required 1 1", gen_req, busy);
        end
        repeat (9) step();
        checks++;
        if (busy !== 1'b1 || error !== 1'b0) begin
            errors++;
            $display("FAIL timeout_cycle10: busy=%b error=%b, required 1 0", busy, error);
        end
        step();
        checks++;
        if ({error, busy, map_ready, gen_req} !== 4'b1000) begin
            errors++;
            $display("FAIL timeout_err: error/busy/map_ready/gen_req=%b, required 1000",
                     {error, busy, map_ready, gen_req});
        end
        start = 1'b1; scroll_req = 1'b1; load_layer_in = 1'b1;
        step();
        step();
        checks++;
        if ({error, busy, map_ready, gen_req} !== 4'b1000) begin
            errors++;
            $display("FAIL timeout_sticky: error/busy/map_ready/gen_req=%b, required 1000",
                     {error, busy, map_ready, gen_req});
        end
        rst = 1'b1;
        step();
        rst = 1'b0;
        checks++;
        if (error !== 1'b0) begin
            errors++;
            $display("FAIL timeout_rst_clear: error=%b, required 0", error);
        end
    endtask

    initial begin
        test_reset();
        test_fill();
        test_scroll();
        test_wrap();
        test_drops();
        test_reset_mid();
        test_timeout();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
